// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU stage.
package alu_pkg;

  localparam int unsigned OPW = 4;

  typedef logic [OPW-1:0] op_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_SUB  = 4'd1;
  localparam op_t OP_AND  = 4'd2;
  localparam op_t OP_OR   = 4'd3;
  localparam op_t OP_XOR  = 4'd4;
  localparam op_t OP_NOT  = 4'd5;
  localparam op_t OP_PASS = 4'd6;
  localparam op_t OP_SHL  = 4'd7;
  localparam op_t OP_SHR  = 4'd8;
  localparam op_t OP_MUL  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Status flags written back alongside C
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
  } flags_t;

  // Opcodes above OP_MUL are unassigned
  function automatic logic is_legal(input op_t op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles.
module mul_shift_add #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done_c,
  output logic [W-1:0] product_c
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          running;
  logic [W-1:0]  addend_c;
  logic          last_c;

  // Partial product for the current iteration; product_c already includes it
  always_comb begin
    addend_c  = mplier[0] ? mcand : '0;
    product_c = acc + addend_c;
    last_c    = (cnt == CW'(W - 1));
    done_c    = running && last_c;
  end

  // Operand load and per-cycle shift/accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_c) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage: latches A/B/op on start, returns result on C with a writeC strobe.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [W-1:0]   C,
  output logic           writeC,
  output logic           busy,
  output logic           zero,
  output logic           neg,
  output logic           carry,
  output logic           err
);

  state_t       state, state_d;
  logic [W-1:0] a_q, b_q;
  op_t          op_q;
  logic [W-1:0] c_q, c_d;
  flags_t       flags_q, flags_d;
  logic         writec_q, writec_d;
  logic         busy_q;
  logic         err_q, err_d;
  logic         load_c, mul_load_c;
  logic [W-1:0] alu_res_c;
  logic         alu_cy_c;
  logic [W-1:0] wres_c;
  logic         wcy_c;
  logic [W:0]   sum_c;
  logic         mul_done_c;
  logic [W-1:0] mul_prod_c;

  mul_shift_add #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .load      (mul_load_c),
    .a         (A),
    .b         (B),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Single-cycle operations on the latched operands
  always_comb begin
    sum_c     = '0;
    alu_res_c = '0;
    alu_cy_c  = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_c     = {1'b0, a_q} + {1'b0, b_q};
        alu_res_c = sum_c[W-1:0];
        alu_cy_c  = sum_c[W];
      end
      OP_SUB: begin
        sum_c     = {1'b0, a_q} - {1'b0, b_q};
        alu_res_c = sum_c[W-1:0];
        alu_cy_c  = sum_c[W];
      end
      OP_AND:  alu_res_c = a_q & b_q;
      OP_OR:   alu_res_c = a_q | b_q;
      OP_XOR:  alu_res_c = a_q ^ b_q;
      OP_NOT:  alu_res_c = ~a_q;
      OP_PASS: alu_res_c = a_q;
      OP_SHL: begin
        alu_res_c = {a_q[W-2:0], 1'b0};
        alu_cy_c  = a_q[W-1];
      end
      OP_SHR: begin
        alu_res_c = {1'b0, a_q[W-1:1]};
        alu_cy_c  = a_q[0];
      end
      default: begin
        alu_res_c = '0;
        alu_cy_c  = 1'b0;
      end
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state;
    load_c     = 1'b0;
    mul_load_c = 1'b0;
    writec_d   = 1'b0;
    err_d      = 1'b0;
    wres_c     = '0;
    wcy_c      = 1'b0;
    c_d        = c_q;
    flags_d    = flags_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_c = 1'b1;
          if (op == OP_MUL) begin
            mul_load_c = 1'b1;
            state_d    = S_MUL;
          end else if (is_legal(op)) begin
            state_d = S_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        writec_d = 1'b1;
        wres_c   = alu_res_c;
        wcy_c    = alu_cy_c;
        state_d  = S_DONE;
      end
      S_MUL: begin
        if (mul_done_c) begin
          writec_d = 1'b1;
          wres_c   = mul_prod_c;
          wcy_c    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    if (writec_d) begin
      c_d           = wres_c;
      flags_d.zero  = (wres_c == '0);
      flags_d.neg   = wres_c[W-1];
      flags_d.carry = wcy_c;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Operand latches, result and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      c_q      <= '0;
      flags_q  <= '{zero: 1'b1, neg: 1'b0, carry: 1'b0};
      writec_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (load_c) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
      c_q      <= c_d;
      flags_q  <= flags_d;
      writec_q <= writec_d;
      busy_q   <= (state_d != S_IDLE);
      err_q    <= err_d;
    end
  end

  assign C      = c_q;
  assign writeC = writec_q;
  assign busy   = busy_q;
  assign zero   = flags_q.zero;
  assign neg    = flags_q.neg;
  assign carry  = flags_q.carry;
  assign err    = err_q;

endmodule
